// File: rtl/wsp_sequencer.sv
// wsp_sequencer: turns one host command into a Capture/Shift/Update sequence on the
// IEEE 1500 WSP of the s349 wrapper, serialising cmd_data onto WSI and collecting WSO.
module wsp_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               WRCK,
  input  logic               WRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               WSI,
  input  logic               WSO,
  output logic               SelectWIR,
  output logic               CaptureWR,
  output logic               ShiftWR,
  output logic               UpdateWR
);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, RESP} state_t;
  state_t             state_q, state_d;
  logic               is_ir_q, is_ir_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [MAX_LEN-1:0] data_q, data_d, rsp_d, sh;
  logic               wsi_d;
  always_comb begin
    state_d = state_q;
    is_ir_d = is_ir_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rsp_d   = rsp_data;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = CAPTURE;
        is_ir_d = cmd_is_ir;
        len_d   = cmd_len > MAX_L ? MAX_L : cmd_len;
        data_d  = cmd_data;
        cnt_d   = '0;
        rsp_d   = '0;
      end
      CAPTURE: state_d = len_q != '0 ? SHIFT : UPDATE;
      SHIFT: begin
        rsp_d   = rsp_data | ({{(MAX_LEN-1){1'b0}}, WSO} << cnt_q);
        cnt_d   = cnt_q + ONE;
        state_d = cnt_q == len_q - ONE ? UPDATE : SHIFT;
      end
      UPDATE:  state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    // outputs are flopped from the next state so they line up with state_q
    sh    = data_d >> cnt_d;
    wsi_d = state_d == SHIFT ? sh[0] : 1'b0;
  end
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      state_q   <= IDLE;
      is_ir_q   <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      rsp_data  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      WSI       <= 1'b0;
      SelectWIR <= 1'b0;
      CaptureWR <= 1'b0;
      ShiftWR   <= 1'b0;
      UpdateWR  <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_ir_q   <= is_ir_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rsp_data  <= rsp_d;
      cmd_ready <= state_d == IDLE;
      rsp_valid <= state_d == RESP;
      WSI       <= wsi_d;
      SelectWIR <= is_ir_d && (state_d == CAPTURE || state_d == SHIFT || state_d == UPDATE);
      CaptureWR <= state_d == CAPTURE;
      ShiftWR   <= state_d == SHIFT;
      UpdateWR  <= state_d == UPDATE;
    end
  end
endmodule

// File: tb/tb_wsp_sequencer.sv
// tb_wsp_sequencer: directed scenario tasks for wsp_sequencer with a small wrapper-side WSO model.
module tb_wsp_sequencer;
  logic        WRCK = 1'b0;
  logic        WRST = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_is_ir = 1'b0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0, rsp_data;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic        WSI, WSO, SelectWIR, CaptureWR, ShiftWR, UpdateWR;
  int          checks = 0, failures = 0;
  int          mode = 0;
  logic        wso_const = 1'b0;
  logic [2:0]  ir_model = '0;
  logic        wsi_d1 = 1'b0;
  int          lat, n_cap, n_shift, n_upd, n_sel, excl, wsi_bad;
  logic [31:0] wsi_seq;

  wsp_sequencer dut (
    .WRCK(WRCK), .WRST(WRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .WSI(WSI), .WSO(WSO), .SelectWIR(SelectWIR), .CaptureWR(CaptureWR),
    .ShiftWR(ShiftWR), .UpdateWR(UpdateWR)
  );

  always #5 WRCK = ~WRCK;

  // 3-bit WIR model captures 3'b010 and shifts WSI in at the MSB; wsi_d1 gives loopback
  always @(posedge WRCK) begin
    if (CaptureWR) ir_model <= 3'b010;
    else if (ShiftWR) ir_model <= {WSI, ir_model[2:1]};
    wsi_d1 <= WSI;
  end
  assign WSO = mode == 1 ? ir_model[0] : mode == 2 ? wsi_d1 : wso_const;

  task automatic tick;
    @(posedge WRCK);
    #1;
  endtask

  task automatic do_cmd(input logic ir, input logic [5:0] len, input logic [31:0] data);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin tick(); w++; end
    cmd_valid = 1'b1; cmd_is_ir = ir; cmd_len = len; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    lat = 1; n_cap = 0; n_shift = 0; n_upd = 0; n_sel = 0; excl = 0; wsi_bad = 0; wsi_seq = '0;
    while (!rsp_valid && lat < 100) begin
      n_cap += int'(CaptureWR);
      n_upd += int'(UpdateWR);
      n_sel += int'(SelectWIR);
      if (int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR) > 1) excl++;
      if (!ShiftWR && WSI) wsi_bad++;
      if (ShiftWR) begin wsi_seq[n_shift] = WSI; n_shift++; end
      tick();
      lat++;
    end
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL handshake {rsp_valid,cmd_ready} got=%b exp=01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_reset;
    WRST = 1'b1; tick(); tick(); WRST = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR} !== 7'b1000000 || rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL reset outs got=%b rsp=%h exp=1000000 rsp=0",
               {cmd_ready, rsp_valid, WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR}, rsp_data);
    end
  endtask

  task automatic test_ir_load;
    mode = 1;
    do_cmd(1'b1, 6'd3, 32'b101);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL ir_latency got=%0d exp=6", lat); end
    checks++;
    if ({n_cap, n_shift, n_upd} !== {32'd1, 32'd3, 32'd1}) begin
      failures++; $display("FAIL ir_pulses cap=%0d shift=%0d upd=%0d exp=1,3,1", n_cap, n_shift, n_upd);
    end
    checks++;
    if (n_sel !== 5) begin failures++; $display("FAIL ir_select_cycles got=%0d exp=5", n_sel); end
    checks++;
    if (wsi_seq[2:0] !== 3'b101) begin failures++; $display("FAIL ir_wsi got=%b exp=101", wsi_seq[2:0]); end
    checks++;
    if (rsp_data !== 32'h2) begin failures++; $display("FAIL ir_rsp got=%h exp=00000002", rsp_data); end
    checks++;
    if (SelectWIR !== 1'b0) begin failures++; $display("FAIL ir_select_in_resp got=%b exp=0", SelectWIR); end
    handshake();
  endtask

  task automatic test_dr_loopback;
    mode = 2;
    do_cmd(1'b0, 6'd32, 32'hA5C3_0F96);
    checks++;
    if (rsp_data !== 32'h4B86_1F2C) begin failures++; $display("FAIL dr_rsp got=%h exp=4b861f2c", rsp_data); end
    checks++;
    if (n_shift !== 32 || n_sel !== 0) begin
      failures++; $display("FAIL dr_shift_sel shift=%0d sel=%0d exp=32,0", n_shift, n_sel);
    end
    checks++;
    if (wsi_seq !== 32'hA5C3_0F96 || wsi_bad !== 0) begin
      failures++; $display("FAIL dr_wsi got=%h bad=%0d exp=a5c30f96,0", wsi_seq, wsi_bad);
    end
    checks++;
    if (lat !== 35) begin failures++; $display("FAIL dr_latency got=%0d exp=35", lat); end
    handshake();
  endtask

  task automatic test_zero_over_len;
    mode = 0; wso_const = 1'b1;
    do_cmd(1'b0, 6'd0, 32'hFFFF_FFFF);
    checks++;
    if (lat !== 3 || n_shift !== 0 || n_cap !== 1 || n_upd !== 1) begin
      failures++; $display("FAIL zero_len lat=%0d shift=%0d cap=%0d upd=%0d exp=3,0,1,1", lat, n_shift, n_cap, n_upd);
    end
    checks++;
    if (rsp_data !== 32'h0) begin failures++; $display("FAIL zero_len_rsp got=%h exp=0", rsp_data); end
    handshake();
    do_cmd(1'b0, 6'd40, 32'h1234_5678);
    checks++;
    if (n_shift !== 32 || lat !== 35) begin
      failures++; $display("FAIL over_len shift=%0d lat=%0d exp=32,35", n_shift, lat);
    end
    checks++;
    if (rsp_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL over_len_rsp got=%h exp=ffffffff", rsp_data); end
    handshake();
  endtask

  task automatic test_backpressure;
    logic [31:0] held;
    int bad, w;
    mode = 0; wso_const = 1'b1;
    do_cmd(1'b0, 6'd4, 32'h0);
    held = rsp_data;
    checks++;
    if (held !== 32'hF) begin failures++; $display("FAIL bp_rsp got=%h exp=0000000f", held); end
    cmd_valid = 1'b1; cmd_is_ir = 1'b1; cmd_len = 6'd2; cmd_data = 32'h3;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_data !== held || cmd_ready || CaptureWR || SelectWIR) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, CaptureWR} !== 3'b010) begin
      failures++; $display("FAIL bp_release {valid,ready,cap} got=%b exp=010", {rsp_valid, cmd_ready, CaptureWR});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, CaptureWR, SelectWIR} !== 3'b011) begin
      failures++; $display("FAIL bp_accept {ready,cap,sel} got=%b exp=011", {cmd_ready, CaptureWR, SelectWIR});
    end
    w = 0;
    while (!rsp_valid && w < 20) begin tick(); w++; end
    checks++;
    if (w !== 4 || rsp_data !== 32'h3) begin
      failures++; $display("FAIL bp_second cycles=%0d rsp=%h exp=4,00000003", w, rsp_data);
    end
    handshake();
  endtask

  task automatic test_reset_mid_shift;
    int upd;
    mode = 0; wso_const = 1'b0;
    upd = 0;
    cmd_valid = 1'b1; cmd_is_ir = 1'b1; cmd_len = 6'd8; cmd_data = 32'hFF;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin upd += int'(UpdateWR); tick(); end
    checks++;
    if (ShiftWR !== 1'b1) begin failures++; $display("FAIL rst_mid_in_shift got=%b exp=1", ShiftWR); end
    WRST = 1'b1;
    tick();
    WRST = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR} !== 7'b1000000) begin
      failures++; $display("FAIL rst_mid_outs got=%b exp=1000000",
                           {cmd_ready, rsp_valid, WSI, SelectWIR, CaptureWR, ShiftWR, UpdateWR});
    end
    for (int i = 0; i < 20; i++) begin upd += int'(UpdateWR); tick(); end
    checks++;
    if (upd !== 0) begin failures++; $display("FAIL rst_mid_no_update got=%0d exp=0", upd); end
  endtask

  task automatic test_random;
    int bad;
    logic [5:0] l;
    int cl;
    logic [63:0] m;
    mode = 0; wso_const = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      l = 6'($urandom_range(0, 63));
      cl = l > 6'd32 ? 32 : int'(l);
      m = (64'd1 << cl) - 64'd1;
      do_cmd(1'($urandom_range(0, 1)), l, $urandom);
      if (excl != 0 || wsi_bad != 0 || n_shift != cl || lat != cl + 3 || rsp_data !== m[31:0]) begin
        bad++;
        if (bad < 5) $display("FAIL rand len=%0d shift=%0d lat=%0d excl=%0d rsp=%h exp_rsp=%h",
                              l, n_shift, lat, excl, rsp_data, m[31:0]);
      end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL rand_total bad_cmds=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_ir_load();
    test_dr_loopback();
    test_zero_over_len();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wsp_sequencer.md
Name: wsp_sequencer

Overview:
- Command-driven controller for the IEEE 1500 wrapper serial port (WSP) of the s349 wrapper.
- Turns one host command into a complete Capture -> Shift -> Update sequence on the WSC signals (SelectWIR, CaptureWR, ShiftWR, UpdateWR).
- Serialises command data onto WSI and collects WSO into a response word.
- Drives either the WIR (instruction load, 3-bit for s349) or the data register currently selected by the WIR.

Parameters:
- MAX_LEN, 32, maximum number of shift bits per command; width of cmd_data and rsp_data.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- WRCK  in  1  wrapper clock; all state changes on the rising edge.
- WRST  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_is_ir  in  1  1 = target the WIR (SelectWIR=1); 0 = target the selected data register.
- cmd_len  in  LEN_W  number of shift cycles.
- cmd_data  in  MAX_LEN  shift-in data; bit 0 is shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  MAX_LEN  captured WSO bits; bit i is the bit sampled in shift cycle i; unused bits are 0.
- WSI  out  1  serial data to the wrapper.
- WSO  in  1  serial data from the wrapper.
- SelectWIR  out  1  WSC select.
- CaptureWR  out  1  WSC capture.
- ShiftWR  out  1  WSC shift.
- UpdateWR  out  1  WSC update.

Behaviour:
- Clocking and reset:
  - Every output is registered and Moore-decoded from the state.
  - WRST=1 at any edge, including mid-sequence, forces state to IDLE on that edge.
  - Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, WSI=0, SelectWIR=0, CaptureWR=0, ShiftWR=0, UpdateWR=0.
  - An aborted sequence issues no UpdateWR.
- States: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, latch cmd_is_ir, cmd_data and len = min(cmd_len, MAX_LEN); clear the bit counter and rsp_data; go to CAPTURE.
  - Command inputs are ignored in every other state because cmd_ready=0.
- CAPTURE (exactly 1 cycle):
  - CaptureWR=1; SelectWIR = latched is_ir.
  - Next state is SHIFT if len>0, else UPDATE.
- SHIFT (exactly len cycles):
  - ShiftWR=1; WSI = data[cnt].
  - At each edge, WSO is stored into rsp_data[cnt] and cnt increments.
  - Leave to UPDATE after the edge where cnt == len-1.
- UPDATE (exactly 1 cycle): UpdateWR=1; next state RESP.
- RESP:
  - rsp_valid=1; rsp_data is stable.
  - On rsp_ready=1, go to IDLE: rsp_valid=0, cmd_ready=1 on the following cycle.
  - rsp_ready while rsp_valid=0 is ignored.
- SelectWIR stays asserted for the whole CAPTURE..UPDATE window when is_ir=1. It is 0 in IDLE and RESP.
- At most one of CaptureWR, ShiftWR, UpdateWR is high in any cycle.
- WSI=0 outside SHIFT.
- Latency from accept edge to rsp_valid = len+3 cycles.
- Back-to-back commands:
  - Minimum gap is one IDLE cycle after the rsp handshake.
  - A cmd_valid held high through RESP is accepted in that IDLE cycle.
- Boundary cases:
  - cmd_len=0: Capture then Update, no shift, rsp_data=0.
  - cmd_len>MAX_LEN: clamped to MAX_LEN.
  - Counter must not wrap at len=MAX_LEN.

Test Plan:
- Reset mid-SHIFT: issue len=8, assert WRST in the 3rd shift cycle -> next cycle all WSC outputs 0, cmd_ready=1, no UpdateWR pulse ever seen.
- IR load: cmd_is_ir=1, len=3, data=3'b101, WSO tied to a 3-bit shift-register model preloaded 3'b010 -> SelectWIR high for 5 cycles; CaptureWR 1 cycle, ShiftWR 3 cycles with WSI=1,0,1, UpdateWR 1 cycle; rsp_valid 6 cycles after accept; rsp_data=0x2.
- DR loopback: cmd_is_ir=0, len=32, data=0xA5C3_0F96, WSO=WSI delayed one cycle -> SelectWIR=0 throughout; rsp_data=0x4B86_1F2C (data<<1, bit0=0); 32 ShiftWR cycles.
- Zero/over length: len=0 -> CAPTURE then UPDATE back-to-back, rsp_data=0; len=40 -> exactly 32 ShiftWR cycles.
- Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, new cmd_valid ignored; after rsp_ready=1, the pending cmd is accepted one cycle later.
- Exclusivity check: random commands (500) -> an assertion that no two of Capture/Shift/Update are high together never fires, and the ShiftWR count per command equals the clamped len.
